// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide controller: op codes, FSM states,
// the default divider width and a small absolute-value helper.
package mdu_ctrl_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int DIV_ITERS_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  // Magnitude of a two's-complement value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> multiply/divide unit signal bundle, plus HI/LO write-back
// port from WB and a debug view of the controller state.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  // start_i is a level request held while the instruction sits in EX; the
  // unit owns EX while stall_o is high and releases it in the done_o cycle.
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic [1:0]  hilo_we_i;
  logic [31:0] hilo_wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  mdu_state_t  state_dbg;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_wdata_i,
    input  stall_o, done_o, div_by_zero_o, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_wdata_i,
    output stall_o, done_o, div_by_zero_o, hi_o, lo_o, state_dbg
  );

endinterface

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned
// magnitudes. The quotient register doubles as the dividend shift register.
module mdu_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         flush_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] quo_q, rem_q, dvs_q;
  logic [W-1:0] quo_d, rem_d;
  logic [W:0]   trial;
  logic         ge;

  always_comb begin
    trial = {rem_q, quo_q[W-1]};
    ge    = (trial >= {1'b0, dvs_q});
    // The difference is below the divisor, so the low W bits are exact.
    rem_d = ge ? (trial[W-1:0] - dvs_q) : trial[W-1:0];
    quo_d = {quo_q[W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (flush_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for EX: sequences MULT/MULTU and DIV/DIVU,
// owns HI/LO, and stalls the front of the pipeline while busy.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 2,
  parameter int DIV_ITERS   = DIV_ITERS_DEF
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  mdu_state_t  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        signed_q, sa_q, sb_q, done_q, dz_q;

  logic        accept, is_div, op_signed, b_zero;
  logic [31:0] abs_a, abs_b, quo, rem, fix_hi_d, fix_lo_d;
  logic [63:0] ext_a, ext_b, prod_d;

  always_comb begin
    is_div    = (bus.op_i == MDU_DIV) || (bus.op_i == MDU_DIVU);
    op_signed = (bus.op_i == MDU_MULT) || (bus.op_i == MDU_DIV);
    b_zero    = (bus.b_i == 32'd0);
    accept    = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    abs_a     = abs32(bus.a_i, op_signed);
    abs_b     = abs32(bus.b_i, op_signed);
  end

  // Sign/zero extension to 64 bits makes one truncated multiply serve both.
  always_comb begin
    ext_a  = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b  = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_d = ext_a * ext_b;
  end

  always_comb begin
    fix_lo_d = (sa_q ^ sb_q) ? (~quo + 32'd1) : quo;
    fix_hi_d = sa_q ? (~rem + 32'd1) : rem;
  end

  mdu_div_iter #(.W(DIV_ITERS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && is_div && !b_zero),
    .step_i     ((state_q == S_DIV) && !bus.flush_i),
    .flush_i    (bus.flush_i),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      // WB writes land first so a same-edge unit result overrides them.
      if (bus.hilo_we_i[1]) hi_q <= bus.hilo_wdata_i;
      if (bus.hilo_we_i[0]) lo_q <= bus.hilo_wdata_i;
      if (bus.flush_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (bus.start_i) begin
            cnt_q    <= '0;
            signed_q <= op_signed;
            if (is_div) begin
              a_q  <= abs_a;
              b_q  <= abs_b;
              sa_q <= op_signed & bus.a_i[31];
              sb_q <= op_signed & bus.b_i[31];
              if (b_zero) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                dz_q    <= 1'b1;
              end else begin
                state_q <= S_DIV;
              end
            end else begin
              a_q     <= bus.a_i;
              b_q     <= bus.b_i;
              sa_q    <= 1'b0;
              sb_q    <= 1'b0;
              state_q <= S_MUL;
            end
          end
          S_MUL: begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'(MULT_CYCLES - 1)) begin
              {hi_q, lo_q} <= prod_d;
              state_q      <= S_DONE;
              done_q       <= 1'b1;
            end
          end
          S_DIV: begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'(DIV_ITERS - 1)) state_q <= S_FIX;
          end
          S_FIX: begin
            hi_q    <= fix_hi_d;
            lo_q    <= fix_lo_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.stall_o       = accept || (state_q == S_MUL) || (state_q == S_DIV) ||
                             (state_q == S_FIX);
  assign bus.done_o        = done_q;
  assign bus.div_by_zero_o = dz_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  assign bus.state_dbg     = state_q;

endmodule
